// File: rtl/cplx_accum_tree_if.sv
// Bus between the per-lane multipliers and the complex adder-tree accumulator.
// The master drives lane data and control; the slave returns results and frame progress.
interface cplx_accum_tree_if #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAME_LEN = 16
);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  logic                        clear;
  logic                        in_valid;
  logic                        in_mode;
  logic [NUM_IN*WIDTH-1:0]     in_real;
  logic [NUM_IN*WIDTH-1:0]     in_imag;
  logic                        out_valid;
  logic [ACC_WIDTH-1:0]        out_real;
  logic [ACC_WIDTH-1:0]        out_imag;
  logic                        out_sat;
  logic [CntW-1:0]             frame_cnt;

  modport master (
    output clear, in_valid, in_mode, in_real, in_imag,
    input  out_valid, out_real, out_imag, out_sat, frame_cnt
  );

  modport slave (
    input  clear, in_valid, in_mode, in_real, in_imag,
    output out_valid, out_real, out_imag, out_sat, frame_cnt
  );
endinterface

// File: rtl/cplx_accum_tree.sv
// Complex adder tree with per-sample or framed, saturating accumulation.
// NUM_IN lanes are reduced through log2(NUM_IN) registered levels, then one output register
// either presents the tree sum (mode 0) or folds it into a FRAME_LEN-sample accumulator (mode 1).
module cplx_accum_tree #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAME_LEN = 16
) (
  input logic               clock,
  input logic               reset_n,
  cplx_accum_tree_if.slave  bus
);

  localparam int          N    = int'(NUM_IN);
  localparam int          L    = $clog2(NUM_IN);
  localparam int          TW   = int'(WIDTH) + L;
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : gen_bad_num_in
    $error("cplx_accum_tree: NUM_IN must be a power of 2 and at least 2");
  end
  if (ACC_WIDTH < WIDTH + L) begin : gen_bad_acc_width
    $error("cplx_accum_tree: ACC_WIDTH must be at least WIDTH + log2(NUM_IN)");
  end
  if (FRAME_LEN < 1) begin : gen_bad_frame_len
    $error("cplx_accum_tree: FRAME_LEN must be at least 1");
  end

  // Heap-ordered tree: node k sums nodes 2k and 2k+1; leaves sit at N..2N-1, root at 1.
  // Every node is held at the final width; the upper bits of shallow levels are plain
  // sign extension, so each level effectively widens by one bit and cannot overflow.
  logic signed [TW-1:0] re_n [2:2*N-1];
  logic signed [TW-1:0] im_n [2:2*N-1];
  logic signed [TW-1:0] re_q [1:N-1];
  logic signed [TW-1:0] im_q [1:N-1];
  logic [L-1:0]         vld_q;
  logic [L-1:0]         mode_q;

  // Gather tree node operands: registered internal nodes plus sign-extended input lanes.
  always_comb begin
    for (int k = 2; k < N; k++) begin
      re_n[k] = re_q[k];
      im_n[k] = im_q[k];
    end
    for (int k = 0; k < N; k++) begin
      re_n[N+k] = TW'($signed(bus.in_real[k*int'(WIDTH) +: WIDTH]));
      im_n[N+k] = TW'($signed(bus.in_imag[k*int'(WIDTH) +: WIDTH]));
    end
  end

  // Tree levels and the valid/mode shift register travelling alongside the data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k < N; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
      vld_q  <= '0;
      mode_q <= '0;
    end else begin
      for (int k = 1; k < N; k++) begin
        re_q[k] <= re_n[2*k] + re_n[2*k+1];
        im_q[k] <= im_n[2*k] + im_n[2*k+1];
      end
      mode_q[0] <= bus.in_mode;
      for (int i = 1; i < L; i++) begin
        mode_q[i] <= mode_q[i-1];
      end
      // clear kills everything in flight, including a sample offered alongside it.
      if (bus.clear) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= bus.in_valid;
        for (int i = 1; i < L; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end
  end

  // Two's-complement add with clamping; returns {clamped, value}.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      // Sign of the wide sum tells which rail was crossed.
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    end
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  logic                        root_vld;
  logic                        root_mode;
  logic signed [ACC_WIDTH-1:0] root_re;
  logic signed [ACC_WIDTH-1:0] root_im;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d, acc_re_sum;
  logic signed [ACC_WIDTH-1:0] acc_im_q, acc_im_d, acc_im_sum;
  logic                        clamp_re, clamp_im;
  logic                        sticky_q, sticky_d;
  logic [CntW-1:0]             cnt_q, cnt_d, cnt_inc;
  logic                        frame_done;
  logic                        out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]        out_re_q, out_re_d;
  logic [ACC_WIDTH-1:0]        out_im_q, out_im_d;
  logic                        out_sat_q, out_sat_d;

  assign root_vld  = vld_q[L-1];
  assign root_mode = mode_q[L-1];
  assign root_re   = ACC_WIDTH'(re_q[1]);
  assign root_im   = ACC_WIDTH'(im_q[1]);

  // Output-stage next state: per-sample pass-through or framed saturating accumulation.
  always_comb begin
    {clamp_re, acc_re_sum} = sat_add(acc_re_q, root_re);
    {clamp_im, acc_im_sum} = sat_add(acc_im_q, root_im);
    cnt_inc     = cnt_q + CntW'(1);
    frame_done  = (cnt_inc == CntW'(FRAME_LEN));
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_sat_d   = out_sat_q;
    if (bus.clear) begin
      acc_re_d = '0;
      acc_im_d = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (root_vld) begin
      if (!root_mode) begin
        // Mode 0 leaves the frame state alone so it can be interleaved inside a frame.
        out_valid_d = 1'b1;
        out_re_d    = root_re;
        out_im_d    = root_im;
        out_sat_d   = 1'b0;
      end else if (frame_done) begin
        out_valid_d = 1'b1;
        out_re_d    = acc_re_sum;
        out_im_d    = acc_im_sum;
        out_sat_d   = sticky_q | clamp_re | clamp_im;
        acc_re_d    = '0;
        acc_im_d    = '0;
        sticky_d    = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_re_d = acc_re_sum;
        acc_im_d = acc_im_sum;
        sticky_d = sticky_q | clamp_re | clamp_im;
        cnt_d    = cnt_inc;
      end
    end
  end

  // Output-stage and accumulator registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_re_q;
  assign bus.out_imag  = out_im_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_cplx_accum_tree.sv
// Bench for cplx_accum_tree: two instances (32-bit acc / 4-sample frames and 26-bit acc /
// 2-sample frames) see the same stimulus and are compared every cycle against a
// transaction-level model of sums, frames and saturation.
module tb_cplx_accum_tree;

  localparam int NI  = 4;
  localparam int W   = 24;
  localparam int LAT = 2;  // cycles from the sampling edge to the output edge: log2(NI)

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  cplx_accum_tree_if #(.NUM_IN(4), .WIDTH(24), .ACC_WIDTH(32), .FRAME_LEN(4)) bus_a ();
  cplx_accum_tree_if #(.NUM_IN(4), .WIDTH(24), .ACC_WIDTH(26), .FRAME_LEN(2)) bus_b ();

  cplx_accum_tree #(.NUM_IN(4), .WIDTH(24), .ACC_WIDTH(32), .FRAME_LEN(4)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  cplx_accum_tree #(.NUM_IN(4), .WIDTH(24), .ACC_WIDTH(26), .FRAME_LEN(2)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus state shared by both instances.
  logic                clr, vin, vmode;
  logic signed [W-1:0] lre [NI];
  logic signed [W-1:0] lim [NI];

  // Reference model.
  typedef struct {
    bit     mode;
    longint re;
    longint im;
    int     due;
  } samp_t;

  int     aw [2] = '{32, 26};
  int     fl [2] = '{4, 2};
  samp_t  pend [$];
  int     cyc = 0;
  longint m_acc_re [2];
  longint m_acc_im [2];
  bit     m_sticky [2];
  int     m_cnt    [2];
  bit     e_v      [2];
  longint e_re     [2];
  longint e_im     [2];
  bit     e_sat    [2];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    pend.delete();
    for (int i = 0; i < 2; i++) begin
      m_acc_re[i] = 0; m_acc_im[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
      e_v[i] = 0; e_re[i] = 0; e_im[i] = 0; e_sat[i] = 0;
    end
  endfunction

  function automatic void sat(input longint v, input int w, output longint r, output bit c);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    c  = (v > hi) || (v < lo);
    r  = (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic apply();
    bus_a.clear = clr; bus_a.in_valid = vin; bus_a.in_mode = vmode;
    bus_b.clear = clr; bus_b.in_valid = vin; bus_b.in_mode = vmode;
    for (int k = 0; k < NI; k++) begin
      bus_a.in_real[k*W +: W] = lre[k]; bus_a.in_imag[k*W +: W] = lim[k];
      bus_b.in_real[k*W +: W] = lre[k]; bus_b.in_imag[k*W +: W] = lim[k];
    end
  endtask

  task automatic set_lanes(input int re, input int im);
    for (int k = 0; k < NI; k++) begin
      lre[k] = W'(re);
      lim[k] = W'(im);
    end
  endtask

  task automatic check_inst(input string nm, input int i, input logic ov,
                            input logic signed [63:0] ore, input logic signed [63:0] oim,
                            input logic os, input logic signed [63:0] ocnt);
    chk({nm, ".out_valid"}, {63'd0, ov}, 64'(e_v[i]));
    chk({nm, ".out_real"}, ore, e_re[i]);
    chk({nm, ".out_imag"}, oim, e_im[i]);
    chk({nm, ".out_sat"}, {63'd0, os}, 64'(e_sat[i]));
    chk({nm, ".frame_cnt"}, ocnt, 64'(m_cnt[i]));
  endtask

  task automatic check_all();
    check_inst("a", 0, bus_a.out_valid, 64'($signed(bus_a.out_real)),
               64'($signed(bus_a.out_imag)), bus_a.out_sat, 64'(bus_a.frame_cnt));
    check_inst("b", 1, bus_b.out_valid, 64'($signed(bus_b.out_real)),
               64'($signed(bus_b.out_imag)), bus_b.out_sat, 64'(bus_b.frame_cnt));
  endtask

  // One clock: present inputs, advance the model at the edge, compare just after it.
  task automatic tick();
    samp_t  s;
    longint sr, si;
    bit     cr, ci;
    apply();
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else if (clr) begin
      pend.delete();
      for (int i = 0; i < 2; i++) begin
        m_acc_re[i] = 0; m_acc_im[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0; e_v[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) e_v[i] = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        s = pend.pop_front();
        for (int i = 0; i < 2; i++) begin
          if (!s.mode) begin
            e_v[i] = 1; e_re[i] = s.re; e_im[i] = s.im; e_sat[i] = 0;
          end else begin
            sat(m_acc_re[i] + s.re, aw[i], sr, cr);
            sat(m_acc_im[i] + s.im, aw[i], si, ci);
            m_sticky[i] = m_sticky[i] | cr | ci;
            m_cnt[i]++;
            if (m_cnt[i] == fl[i]) begin
              e_v[i] = 1; e_re[i] = sr; e_im[i] = si; e_sat[i] = m_sticky[i];
              m_acc_re[i] = 0; m_acc_im[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
            end else begin
              m_acc_re[i] = sr; m_acc_im[i] = si;
            end
          end
        end
      end
      if (vin) begin
        s.mode = vmode; s.re = 0; s.im = 0; s.due = cyc + LAT;
        for (int k = 0; k < NI; k++) begin
          s.re += longint'(lre[k]);
          s.im += longint'(lim[k]);
        end
        pend.push_back(s);
      end
    end
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset_pulse();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr = 0; vin = 0; vmode = 0;
    set_lanes(0, 0);
    model_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset while garbage is flowing through the tree.
    vin = 1;
    for (int n = 0; n < 3; n++) begin
      vmode = 1'($urandom_range(0, 1));
      for (int k = 0; k < NI; k++) begin
        lre[k] = W'($urandom()); lim[k] = W'($urandom());
      end
      tick();
    end
    async_reset_pulse();
    vin = 0;
    tick(); tick(); tick();
    chk("reset.a.out_real_zero", 64'($signed(bus_a.out_real)), 64'(0));
    chk("reset.a.frame_cnt_zero", 64'(bus_a.frame_cnt), 64'(0));

    // Mode 0: single tree sum, visible after the third edge.
    vmode = 0; vin = 1;
    for (int k = 0; k < NI; k++) begin
      lre[k] = W'(k + 1); lim[k] = W'(-(k + 1));
    end
    tick();
    vin = 0;
    tick();
    chk("mode0.a.early_valid", {63'd0, bus_a.out_valid}, 64'(0));
    tick();
    chk("mode0.a.valid", {63'd0, bus_a.out_valid}, 64'(1));
    chk("mode0.a.real", 64'($signed(bus_a.out_real)), 64'(10));
    chk("mode0.a.imag", 64'($signed(bus_a.out_imag)), 64'(-10));
    chk("mode0.a.sat", {63'd0, bus_a.out_sat}, 64'(0));
    tick();

    // Mode 1: four samples with bubbles in between.
    vmode = 1;
    set_lanes(100, -7);
    for (int n = 0; n < 4; n++) begin
      vin = 1; tick();
      vin = 0; tick();
    end
    tick();
    chk("mode1.a.valid", {63'd0, bus_a.out_valid}, 64'(1));
    chk("mode1.a.real", 64'($signed(bus_a.out_real)), 64'(1600));
    chk("mode1.a.imag", 64'($signed(bus_a.out_imag)), 64'(-112));
    chk("mode1.a.frame_cnt", 64'(bus_a.frame_cnt), 64'(0));
    tick();

    // Saturation frame on the narrow instance, then a clean follow-up frame.
    set_lanes(8388607, -8388608);
    vin = 1; tick(); tick();
    vin = 0; tick(); tick();
    chk("sat.b.valid", {63'd0, bus_b.out_valid}, 64'(1));
    chk("sat.b.real", 64'($signed(bus_b.out_real)), 64'(33554431));
    chk("sat.b.imag", 64'($signed(bus_b.out_imag)), 64'(-33554432));
    chk("sat.b.sat", {63'd0, bus_b.out_sat}, 64'(1));
    set_lanes(1, 1);
    vin = 1; tick(); tick();
    vin = 0; tick(); tick();
    chk("sat.b.next_real", 64'($signed(bus_b.out_real)), 64'(8));
    chk("sat.b.next_imag", 64'($signed(bus_b.out_imag)), 64'(8));
    chk("sat.b.next_sat", {63'd0, bus_b.out_sat}, 64'(0));
    tick();

    // Interleave a mode-0 sample inside a frame, then clear with work in flight.
    vin = 1; vmode = 1; set_lanes(3, 3); tick();
    vmode = 0; set_lanes(5, 5); tick();
    vmode = 1; set_lanes(3, 3); tick();
    vin = 0; tick();
    chk("ilv.a.mode0_valid", {63'd0, bus_a.out_valid}, 64'(1));
    chk("ilv.a.mode0_real", 64'($signed(bus_a.out_real)), 64'(20));
    chk("ilv.a.frame_cnt", 64'(bus_a.frame_cnt), 64'(1));
    vin = 1; tick();
    clr = 1; set_lanes(9, 9); tick();
    clr = 0; vin = 0;
    chk("clear.a.frame_cnt", 64'(bus_a.frame_cnt), 64'(0));
    tick(); tick(); tick();
    chk("clear.a.no_valid", {63'd0, bus_a.out_valid}, 64'(0));
    vin = 1; set_lanes(2, -2);
    tick(); tick(); tick(); tick();
    vin = 0; tick(); tick();
    chk("clear.a.next_real", 64'($signed(bus_a.out_real)), 64'(32));
    chk("clear.a.next_imag", 64'($signed(bus_a.out_imag)), 64'(-32));
    tick();

    // Reset in the middle of a frame.
    vin = 1; set_lanes(7, 7); tick(); tick();
    vin = 0; tick(); tick(); tick();
    async_reset_pulse();
    vin = 1; set_lanes(1, 1);
    tick(); tick(); tick(); tick();
    vin = 0; tick(); tick();
    chk("rstmid.a.valid", {63'd0, bus_a.out_valid}, 64'(1));
    chk("rstmid.a.real", 64'($signed(bus_a.out_real)), 64'(16));
    tick();

    // Random traffic with occasional clears.
    for (int n = 0; n < 120; n++) begin
      vin   = ($urandom_range(0, 3) != 0);
      vmode = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < NI; k++) begin
        lre[k] = W'($urandom()); lim[k] = W'($urandom());
      end
      tick();
    end
    clr = 0; vin = 0;
    tick(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
